// File: rtl/seg_readback_if.sv
// Segment readback bus: the pattern pair sampled from the display
// encoder and the decoded status returned to the supervisor.
interface seg_readback_if #(
  parameter int ERR_CNT_W = 8
);
  logic [7:0]           seg1;
  logic [7:0]           seg2;
  logic [7:0]           value;
  logic                 value_valid;
  logic                 service;
  logic                 blank;
  logic                 error;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output seg1, seg2,
    input  value, value_valid, service,
    input  blank, error, err_count
  );

  modport slave (
    input  seg1, seg2,
    output value, value_valid, service,
    output blank, error, err_count
  );
endinterface

// File: rtl/seg_readback_decoder.sv
// Readback checker for the two-digit countdown display: debounces
// the seg1/seg2 pair and classifies each stable pair.
module seg_readback_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  seg_readback_if.slave bus
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          pair, samp_q, cmt_q;
  logic                 cmt_vld_q;
  logic [RW-1:0]        run_q, run_d;
  logic                 same, commit, fresh;
  logic [4:0]           d1, d2;
  logic                 is_dig, is_svc, is_blk;
  logic [7:0]           value_q, num;
  logic                 vv_q, svc_q, blk_q, err_q;
  logic [ERR_CNT_W-1:0] cnt_q;

  // {found, digit} for an exact segment-pattern match
  function automatic logic [4:0] seg_dig(input logic [7:0] s);
    unique case (s)
      8'hFC:   return 5'h10;
      8'h60:   return 5'h11;
      8'hDA:   return 5'h12;
      8'hF2:   return 5'h13;
      8'h66:   return 5'h14;
      8'hB6:   return 5'h15;
      8'hBE:   return 5'h16;
      8'hE0:   return 5'h17;
      8'hFE:   return 5'h18;
      8'hF6:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    pair    = {bus.seg1, bus.seg2};
    same    = (state_q != IDLE) && (pair == samp_q);
    run_d   = RW'(1);
    if (same)
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE:   state_d = TRACK;
      TRACK: begin
        if (run_q == RUN_MAX) begin
          commit  = 1'b1;
          state_d = same ? LOCKED : TRACK;
        end
      end
      LOCKED: if (!same) state_d = TRACK;
      default: state_d = IDLE;
    endcase
    // a pair identical to the last committed one is absorbed silently
    fresh = commit && (!cmt_vld_q || samp_q != cmt_q);
  end

  always_comb begin
    d1     = seg_dig(samp_q[15:8]);
    d2     = seg_dig(samp_q[7:0]);
    is_dig = d1[4] && d2[4];
    is_svc = samp_q == 16'h0202;
    is_blk = samp_q == 16'hFFFF;
    num    = {4'd0, d1[3:0]} * 8'd10 + {4'd0, d2[3:0]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      samp_q    <= '0;
      run_q     <= '0;
      cmt_q     <= '0;
      cmt_vld_q <= 1'b0;
      value_q   <= '0;
      vv_q      <= 1'b0;
      svc_q     <= 1'b0;
      blk_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= pair;
      run_q   <= run_d;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
      if (fresh) begin
        cmt_q     <= samp_q;
        cmt_vld_q <= 1'b1;
        unique case (1'b1)
          is_dig: begin
            value_q <= num;
            vv_q    <= 1'b1;
            svc_q   <= 1'b0;
            blk_q   <= 1'b0;
          end
          is_svc: begin
            svc_q <= 1'b1;
            blk_q <= 1'b0;
          end
          is_blk: begin
            svc_q <= 1'b0;
            blk_q <= 1'b1;
          end
          default: begin
            err_q <= 1'b1;
            if (cnt_q != '1)
              cnt_q <= cnt_q + 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;
  assign bus.service     = svc_q;
  assign bus.blank       = blk_q;
  assign bus.error       = err_q;
  assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Bench for seg_readback_decoder: vector table, directed corner
// sequences and random holds against a run-length reference model.
module tb_seg_readback_decoder;

  logic clk;
  logic rst;

  seg_readback_if #(.ERR_CNT_W(8)) bus ();
  seg_readback_if #(.ERR_CNT_W(8)) bus1 ();

  seg_readback_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  seg_readback_decoder #(.STABLE_CYCLES(1), .ERR_CNT_W(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          run;
    logic [15:0] prev;
    bit          have;
    bit          cvld;
    logic [15:0] cmt;
    logic [7:0]  value;
    bit          vv, svc, blk, err;
    int          cnt;
  } model_t;

  model_t m0, m1;

  typedef struct {
    logic [7:0] s1, s2;
    logic [7:0] val;
    logic       vv, svc, blk, err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic int dig_of(input logic [7:0] s);
    logic [7:0] tbl [10];
    tbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
            8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    for (int i = 0; i < 10; i++)
      if (tbl[i] == s) return i;
    return -1;
  endfunction

  // A pair commits one edge after its uninterrupted run reaches s.
  function automatic model_t mstep(model_t m, logic [15:0] p, int s);
    model_t n;
    int t, u;
    n = m;
    n.vv = 0;
    n.err = 0;
    if (m.have && m.run == s && (!m.cvld || m.prev != m.cmt)) begin
      n.cvld = 1;
      n.cmt = m.prev;
      t = dig_of(m.prev[15:8]);
      u = dig_of(m.prev[7:0]);
      if (t >= 0 && u >= 0) begin
        n.value = 8'(t * 10 + u);
        n.vv = 1; n.svc = 0; n.blk = 0;
      end else if (m.prev == 16'h0202) begin
        n.svc = 1; n.blk = 0;
      end else if (m.prev == 16'hFFFF) begin
        n.svc = 0; n.blk = 1;
      end else begin
        n.err = 1;
        if (n.cnt < 255) n.cnt++;
      end
    end
    n.run = (m.have && p == m.prev) ? m.run + 1 : 1;
    n.prev = p;
    n.have = 1;
    return n;
  endfunction

  function automatic logic [31:0] pk(logic [7:0] v, logic a, logic b,
                                     logic c, logic d, logic [7:0] n);
    return {12'd0, v, a, b, c, d, n};
  endfunction

  function automatic logic [31:0] pm(model_t m);
    return pk(m.value, m.vv, m.svc, m.blk, m.err, 8'(m.cnt));
  endfunction

  function automatic logic [31:0] p0();
    return pk(bus.value, bus.value_valid, bus.service,
              bus.blank, bus.error, bus.err_count);
  endfunction

  function automatic logic [31:0] p1();
    return pk(bus1.value, bus1.value_valid, bus1.service,
              bus1.blank, bus1.error, bus1.err_count);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [7:0] a, input logic [7:0] b,
                      input logic r);
    bus.seg1 = a;  bus.seg2 = b;
    bus1.seg1 = a; bus1.seg2 = b;
    rst = r;
    @(posedge clk);
    if (!r) begin
      m0 = '{default: 0};
      m1 = '{default: 0};
    end else begin
      m0 = mstep(m0, {a, b}, 4);
      m1 = mstep(m1, {a, b}, 1);
    end
    #1;
    chk("model_s4", p0(), pm(m0));
    chk("model_s1", p1(), pm(m1));
  endtask

  function automatic void add(logic [7:0] s1, logic [7:0] s2,
                              logic [7:0] v, logic vv, logic svc,
                              logic blk, logic err, logic [7:0] c);
    vecs.push_back('{s1, s2, v, vv, svc, blk, err, c});
  endfunction

  initial begin
    int pulses;
    logic [7:0] a, b;
    logic [15:0] pool [8];

    // hold F2/B6, then service, blank, 99, then an invalid pair
    for (int i = 0; i < 4; i++) add(8'hF2, 8'hB6, 0, 0, 0, 0, 0, 0);
    add(8'hF2, 8'hB6, 35, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(8'hF2, 8'hB6, 35, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(8'h02, 8'h02, 35, 0, 0, 0, 0, 0);
    add(8'h02, 8'h02, 35, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(8'hFF, 8'hFF, 35, 0, 1, 0, 0, 0);
    add(8'hFF, 8'hFF, 35, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(8'hF6, 8'hF6, 35, 0, 0, 1, 0, 0);
    add(8'hF6, 8'hF6, 99, 1, 0, 0, 0, 0);
    add(8'hF6, 8'hF6, 99, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(8'h02, 8'h60, 99, 0, 0, 0, 0, 0);
    add(8'h02, 8'h60, 99, 0, 0, 0, 1, 1);
    add(8'h02, 8'h60, 99, 0, 0, 0, 0, 1);

    m0 = '{default: 0};
    m1 = '{default: 0};
    tick(8'h00, 8'h00, 0);
    tick(8'h00, 8'h00, 0);
    chk("reset_s4", p0(), 0);
    chk("reset_s1", p1(), 0);

    foreach (vecs[i]) begin
      tick(vecs[i].s1, vecs[i].s2, 1);
      chk($sformatf("tbl[%0d]", i), p0(),
          pk(vecs[i].val, vecs[i].vv, vecs[i].svc,
             vecs[i].blk, vecs[i].err, vecs[i].cnt));
    end

    // error counter saturation with alternating distinct invalid pairs
    for (int i = 0; i < 300; i++) begin
      a = (i % 2 == 1) ? 8'h01 : 8'h03;
      b = 8'(i);
      for (int k = 0; k < 4; k++) tick(a, b, 1);
    end
    tick(a, b, 1);
    tick(a, b, 1);
    chk("err_sat", p0(), pk(99, 0, 0, 0, 0, 8'hFF));

    // glitch back to the committed pattern is silent
    for (int i = 0; i < 6; i++) tick(8'hFC, 8'h60, 1);
    chk("glitch_base", bus.value, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 2) tick(8'h66, 8'h66, 1);
      else tick(8'hFC, 8'h60, 1);
      pulses += int'(bus.value_valid) + int'(bus.error);
    end
    chk("glitch_quiet", pulses, 0);
    chk("glitch_val", bus.value, 1);

    // reset mid-run discards the partial run
    for (int i = 0; i < 3; i++) tick(8'hFE, 8'hF6, 1);
    tick(8'hFE, 8'hF6, 0);
    chk("midrst_s4", p0(), 0);
    chk("midrst_s1", p1(), 0);
    for (int i = 0; i < 4; i++) begin
      tick(8'hFE, 8'hF6, 1);
      chk("midrst_wait", p0(), 0);
    end
    tick(8'hFE, 8'hF6, 1);
    chk("midrst_commit", p0(), pk(89, 1, 0, 0, 0, 0));
    tick(8'hFE, 8'hF6, 1);
    chk("midrst_hold", p0(), pk(89, 0, 0, 0, 0, 0));

    // single-cycle window: toggle every two edges
    for (int k = 0; k < 4; k++) begin
      a = (k % 2 == 0) ? 8'hDA : 8'hE0;
      b = (k % 2 == 0) ? 8'hFC : 8'hE0;
      tick(a, b, 1);
      chk("s1_first", bus1.value_valid, 0);
      tick(a, b, 1);
      chk("s1_commit", {bus1.value, bus1.value_valid},
          {((k % 2 == 0) ? 8'd20 : 8'd77), 1'b1});
    end

    // pattern changing every edge never settles
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) tick(8'h60, 8'h60, 1);
      else tick(8'hB6, 8'hB6, 1);
      pulses += int'(bus.value_valid) + int'(bus.error);
    end
    chk("toggle_quiet", pulses, 0);

    // random holds checked every edge against the model
    pool = '{16'hF2B6, 16'hFC60, 16'hDAFC, 16'hE0E0,
             16'hF6F6, 16'h0202, 16'hFFFF, 16'h0260};
    for (int s = 0; s < 150; s++) begin
      int r, h;
      logic [15:0] p;
      r = $urandom_range(0, 9);
      p = (r < 8) ? pool[r] : 16'($urandom);
      h = $urandom_range(1, 6);
      for (int k = 0; k < h; k++)
        tick(p[15:8], p[7:0], $urandom_range(0, 49) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
